watch_set_cu: RTL

Control unit for the watch time-set function. It sequences edit mode over the hour, minute and second fields. Debounced up/down button levels become single-cycle increment/decrement strobes, with hold-to-auto-repeat. Sits between the button debouncers and the watch counter datapath, which applies o_inc/o_dec to the field selected by o_field.

---
 rtl/watch_set_cu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/watch_set_cu.sv
// Watch time-set control unit: edit-field sequencing, press/auto-repeat strobes and edit timeout.
// Optional macro WATCH_SET_BLINK_EN adds a blinking field indicator; otherwise o_blink follows o_edit.
module watch_set_cu #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int BLINK_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_mode,
  input  logic       i_up,
  input  logic       i_down,
  output logic       o_edit,
  output logic [1:0] o_field,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_blink
);

  typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC} state_t;
  typedef enum logic [1:0] {KEY_NONE, KEY_UP, KEY_DN} key_t;
  typedef enum logic [1:0] {PH_OFF, PH_HOLD, PH_REPEAT} phase_t;

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);
  localparam int PH_W   = (HOLD_W > REP_W) ? HOLD_W : REP_W;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] REP_LAST  = PH_W'(REPEAT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_bad_params
    $error("watch_set_cu: cycle parameters out of range");
  end

  state_t          state, next_state;
  key_t            dir, prev_dir;
  phase_t          phase, phase_nx;
  logic [PH_W-1:0] ph_cnt, ph_cnt_nx;
  logic [TO_W-1:0] to_cnt;
  logic            can_strobe, strobe_nx, inc_nx, dec_nx;

  always_comb begin
    dir = KEY_NONE;
    if (i_up && !i_down) dir = KEY_UP;
    else if (i_down && !i_up) dir = KEY_DN;
  end

  always_comb begin
    next_state = state;
    if (!i_enable) begin
      next_state = IDLE;
    end else if (i_mode) begin
      case (state)
        IDLE:      next_state = EDIT_HOUR;
        EDIT_HOUR: next_state = EDIT_MIN;
        EDIT_MIN:  next_state = EDIT_SEC;
        default:   next_state = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      next_state = IDLE;
    end
  end

  // Strobes only fire while staying in one edit field; any field change drops the key phase.
  always_comb begin
    can_strobe = (state != IDLE) && (next_state == state);
    phase_nx   = phase;
    ph_cnt_nx  = ph_cnt;
    strobe_nx  = 1'b0;
    if (can_strobe && dir != KEY_NONE && dir != prev_dir) begin
      phase_nx  = PH_HOLD;
      ph_cnt_nx = '0;
      strobe_nx = 1'b1;
    end else if (!can_strobe || dir != prev_dir || dir == KEY_NONE) begin
      phase_nx  = PH_OFF;
      ph_cnt_nx = '0;
    end else begin
      case (phase)
        PH_HOLD: begin
          if (ph_cnt == HOLD_LAST) begin
            phase_nx  = PH_REPEAT;
            ph_cnt_nx = '0;
            strobe_nx = 1'b1;
          end else begin
            ph_cnt_nx = ph_cnt + 1'b1;
          end
        end
        PH_REPEAT: begin
          if (ph_cnt == REP_LAST) begin
            ph_cnt_nx = '0;
            strobe_nx = 1'b1;
          end else begin
            ph_cnt_nx = ph_cnt + 1'b1;
          end
        end
        default: begin
          phase_nx  = PH_OFF;
          ph_cnt_nx = '0;
        end
      endcase
    end
    inc_nx = strobe_nx && (dir == KEY_UP);
    dec_nx = strobe_nx && (dir == KEY_DN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prev_dir <= KEY_NONE;
      phase    <= PH_OFF;
      ph_cnt   <= '0;
      to_cnt   <= '0;
      o_inc    <= 1'b0;
      o_dec    <= 1'b0;
    end else begin
      state    <= next_state;
      prev_dir <= dir;
      phase    <= phase_nx;
      ph_cnt   <= ph_cnt_nx;
      o_inc    <= inc_nx;
      o_dec    <= dec_nx;
      if (state == IDLE || next_state != state || i_mode || i_up || i_down || o_inc || o_dec)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
    end
  end

  assign o_edit = (state != IDLE);

  always_comb begin
    case (state)
      EDIT_HOUR: o_field = 2'd0;
      EDIT_MIN:  o_field = 2'd1;
      EDIT_SEC:  o_field = 2'd2;
      default:   o_field = 2'd3;
    endcase
  end

`ifdef WATCH_SET_BLINK_EN
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

  logic [BL_W-1:0] blink_cnt;
  logic            blink_q;

  // Blink restarts visible on entry, field change and every strobe so the edited value stays readable.
  always_ff @(posedge clk) begin
    if (rst || next_state == IDLE) begin
      blink_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (next_state != state || inc_nx || dec_nx) begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BL_LAST) begin
      blink_q   <= ~blink_q;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign o_blink = blink_q;
`else
  assign o_blink = o_edit;
`endif

endmodule
